// File: rtl/multicycle_decoder_if.sv
// -----------------------------------------------------------------------------
// multicycle_decoder_if
// Memory handshake bundle between the multicycle decoder and the memory port.
//   mem_req   : decoder requests a memory access this cycle
//   mem_ready : memory completes the current request this cycle
//   MemW      : write strobe (store)
//   AdrSrc    : address select, 0 = PC, 1 = ALU result
//   memSelect : {signed, size}; size 0 = byte, 1 = half, 2 = word
// master = decoder side, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_decoder_if;
   logic       mem_req;
   logic       mem_ready;
   logic       MemW;
   logic       AdrSrc;
   logic [2:0] memSelect;

   modport master (
      output mem_req,
      output MemW,
      output AdrSrc,
      output memSelect,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  MemW,
      input  AdrSrc,
      input  memSelect,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_decoder
// Control FSM of a multicycle ARM-style core. Sequences fetch, decode,
// register/immediate execute, ALU writeback, load/store and branch, and drops
// into a sticky FAULT state on illegal encodings or memory timeouts.
// Ports:
//   clk, reset (async, active low)
//   bus        : memory handshake (mem_req, mem_ready, MemW, AdrSrc, memSelect)
//   Op, Funct, Rd, Instr[11:4] : fields from the instruction register
//   IRWrite, PCWrite, RegW, linkSelect : register-file / PC enables
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW,
//   shiftOp, registerShift : datapath controls
//   fault : sticky error, state : current state encoding
// -----------------------------------------------------------------------------
module multicycle_decoder #(
   parameter int MAX_WAIT    = 15,
   parameter bit HALFWORD_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_decoder_if.master  bus,
   input  logic [1:0]            Op,
   input  logic [5:0]            Funct,
   input  logic [3:0]            Rd,
   input  logic [11:4]           Instr,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  RegW,
   output logic                  linkSelect,
   output logic [1:0]            ResultSrc,
   output logic                  ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            RegSrc,
   output logic [3:0]            ALUControl,
   output logic [3:0]            FlagW,
   output logic [2:0]            shiftOp,
   output logic                  registerShift,
   output logic                  fault,
   output logic [3:0]            state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_RSHIFT = 4'd2,
      S_EXECR  = 4'd3,
      S_EXECI  = 4'd4,
      S_ALUWB  = 4'd5,
      S_MEMADR = 4'd6,
      S_MEMRD  = 4'd7,
      S_MEMWB  = 4'd8,
      S_MEMWR  = 4'd9,
      S_BRANCH = 4'd10,
      S_FAULT  = 4'd11
   } state_t;

   localparam int           W    = $clog2(MAX_WAIT + 1);
   localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);
   localparam logic [3:0]   ALU_ADD = 4'b0100;
   localparam logic [2:0]   SH_ROR  = 3'd3;
   localparam logic [2:0]   SH_RRX  = 3'd4;
   localparam logic [2:0]   SH_PASS = 3'd5;

   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [2:0]   memsel_q, memsel_d;
   logic         run_q;

   logic         extra_ls;
   logic         waiting;
   logic         timeout;
   logic [2:0]   memsel_dec;
   logic [2:0]   exec_shift;

   logic         mem_req_c, memw_c, adrsrc_c;

   // Extra load/store space: bit7 & bit4 set with a non-zero SH field.
   assign extra_ls = Instr[7] & Instr[4] & (Instr[6:5] != 2'b00);
   assign waiting  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timeout  = waiting & ~bus.mem_ready & (cnt_q == LAST);

   // Access size/sign chosen at decode; stores never sign-extend.
   always_comb begin
      memsel_dec = 3'b010;
      if (Op == 2'b01) begin
         memsel_dec = Funct[2] ? 3'b000 : 3'b010;
      end else begin
         case (Instr[6:5])
            2'b01:   memsel_dec = 3'b001;
            2'b10:   memsel_dec = 3'b100;
            2'b11:   memsel_dec = 3'b101;
            default: memsel_dec = 3'b010;
         endcase
      end
      if (!Funct[0]) memsel_dec[2] = 1'b0;
   end

   // Register-operand shift: ROR #0 encodes RRX.
   always_comb begin
      exec_shift = {1'b0, Instr[6:5]};
      if ((Instr[11:7] == 5'd0) && !Instr[4] && (Instr[6:5] == 2'b11)) exec_shift = SH_RRX;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         cnt_q    <= '0;
         memsel_q <= 3'b000;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         memsel_q <= memsel_d;
         run_q    <= 1'b1;
      end
   end

   // Next-state logic. run_q holds the FSM in FETCH with all strobes low for
   // the partial cycle between reset release and the first rising edge.
   always_comb begin
      state_d  = state_q;
      memsel_d = memsel_q;
      if (run_q) begin
         case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
               case (Op)
                  2'b10: state_d = S_BRANCH;
                  2'b01: begin
                     state_d  = S_MEMADR;
                     memsel_d = memsel_dec;
                  end
                  2'b00: begin
                     if (extra_ls) begin
                        if (HALFWORD_EN) begin
                           state_d  = S_MEMADR;
                           memsel_d = memsel_dec;
                        end else begin
                           state_d = S_FAULT;
                        end
                     end else if (Funct[5]) begin
                        state_d = S_EXECI;
                     end else if (Instr[4] && !Instr[7]) begin
                        state_d = S_RSHIFT;
                     end else begin
                        state_d = S_EXECR;
                     end
                  end
                  default: state_d = S_FAULT;
               endcase
            end
            S_RSHIFT: state_d = S_EXECR;
            S_EXECR,
            S_EXECI:  state_d = (Funct[4:3] == 2'b10) ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
         endcase
         if (timeout) state_d = S_FAULT;
      end
   end

   // Counter runs only while staying in a waiting state without ready; any
   // entry, completion or exit leaves it at zero.
   always_comb begin
      cnt_d = '0;
      if (run_q && waiting && !bus.mem_ready && (state_d == state_q)) cnt_d = cnt_q + W'(1);
   end

   // Output decode.
   always_comb begin
      mem_req_c     = 1'b0;
      memw_c        = 1'b0;
      adrsrc_c      = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegW          = 1'b0;
      linkSelect    = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ImmSrc        = 2'b00;
      RegSrc        = 2'b00;
      ALUControl    = ALU_ADD;
      FlagW         = 4'b0000;
      shiftOp       = SH_PASS;
      registerShift = 1'b0;
      bus.memSelect = 3'b000;
      if (run_q) begin
         case (state_q)
            S_FETCH: begin
               mem_req_c = 1'b1;
               if (bus.mem_ready) begin
                  IRWrite   = 1'b1;
                  PCWrite   = 1'b1;
                  ALUSrcA   = 1'b1;
                  ALUSrcB   = 2'b10;
                  ResultSrc = 2'b10;
               end
            end
            S_DECODE: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_RSHIFT: registerShift = 1'b1;
            S_EXECR, S_EXECI: begin
               ALUControl = Funct[4:1];
               if (state_q == S_EXECI) begin
                  shiftOp = SH_ROR;
                  ALUSrcB = 2'b01;
               end else begin
                  shiftOp = exec_shift;
               end
               if (Funct[4:2] == 3'b101)      FlagW = 4'b1111;
               else if (Funct[4:2] == 3'b100) FlagW = 4'b1110;
               else                           FlagW = {{3{Funct[0]}}, 1'b0};
            end
            S_ALUWB: begin
               RegW    = 1'b1;
               PCWrite = (Rd == 4'd15);
            end
            S_MEMADR: begin
               ALUSrcB       = 2'b01;
               bus.memSelect = memsel_q;
            end
            S_MEMRD: begin
               mem_req_c     = 1'b1;
               adrsrc_c      = 1'b1;
               bus.memSelect = memsel_q;
            end
            S_MEMWB: begin
               RegW          = 1'b1;
               ResultSrc     = 2'b01;
               PCWrite       = (Rd == 4'd15);
               bus.memSelect = memsel_q;
            end
            S_MEMWR: begin
               mem_req_c     = 1'b1;
               memw_c        = 1'b1;
               adrsrc_c      = 1'b1;
               bus.memSelect = memsel_q;
            end
            S_BRANCH: begin
               PCWrite    = 1'b1;
               ImmSrc     = 2'b10;
               ALUSrcB    = 2'b01;
               RegW       = Funct[4];
               linkSelect = Funct[4];
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req = mem_req_c;
   assign bus.MemW    = memw_c;
   assign bus.AdrSrc  = adrsrc_c;
   assign fault       = (state_q == S_FAULT);
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_decoder.sv
module tb_multicycle_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [5:0]  Funct = 6'b0;
   logic [3:0]  Rd = 4'd0;
   logic [11:4] Instr = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_decoder_if bus0();
   multicycle_decoder_if bus1();

   logic       IRWrite, PCWrite, RegW, linkSelect, ALUSrcA, registerShift, fault;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [3:0] ALUControl, FlagW, state;
   logic [2:0] shiftOp;

   logic       IRWrite_h, PCWrite_h, RegW_h, linkSelect_h, ALUSrcA_h, registerShift_h, fault_h;
   logic [1:0] ResultSrc_h, ALUSrcB_h, ImmSrc_h, RegSrc_h;
   logic [3:0] ALUControl_h, FlagW_h, state_h;
   logic [2:0] shiftOp_h;

   multicycle_decoder #(.MAX_WAIT(15), .HALFWORD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(bus0),
      .Op(Op), .Funct(Funct), .Rd(Rd), .Instr(Instr),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegW(RegW), .linkSelect(linkSelect),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW),
      .shiftOp(shiftOp), .registerShift(registerShift), .fault(fault), .state(state)
   );

   multicycle_decoder #(.MAX_WAIT(15), .HALFWORD_EN(1'b0)) dut_h (
      .clk(clk), .reset(reset), .bus(bus1),
      .Op(Op), .Funct(Funct), .Rd(Rd), .Instr(Instr),
      .IRWrite(IRWrite_h), .PCWrite(PCWrite_h), .RegW(RegW_h), .linkSelect(linkSelect_h),
      .ResultSrc(ResultSrc_h), .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h),
      .ImmSrc(ImmSrc_h), .RegSrc(RegSrc_h), .ALUControl(ALUControl_h), .FlagW(FlagW_h),
      .shiftOp(shiftOp_h), .registerShift(registerShift_h), .fault(fault_h), .state(state_h)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic v);
      bus0.mem_ready = v;
      bus1.mem_ready = v;
   endtask

   task automatic pulse_reset();
      #3 reset = 1'b0;
      #2 reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
      n_checks++; if (bus0.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", bus0.mem_req); end
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fault); end
      #4 reset = 1'b1;
      #1;
      n_checks++; if (bus0.mem_req !== 1'b0) begin n_fail++; $display("FAIL release_pre_edge_mem_req got=%b exp=0", bus0.mem_req); end
      step();
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL release_state got=%0d exp=0", state); end
      n_checks++; if (bus0.mem_req !== 1'b1) begin n_fail++; $display("FAIL release_mem_req got=%b exp=1", bus0.mem_req); end
      n_checks++; if (bus0.AdrSrc !== 1'b0) begin n_fail++; $display("FAIL release_adrsrc got=%b exp=0", bus0.AdrSrc); end
      $display("test_reset done");
   endtask

   task automatic test_add_imm();
      Op = 2'b00; Funct = 6'b101000; Instr = 8'h00; Rd = 4'd1; set_ready(1'b1);
      #1;
      n_checks++; if ({IRWrite, PCWrite, ALUSrcA} !== 3'b111) begin n_fail++; $display("FAIL fetch_enables got=%b exp=111", {IRWrite, PCWrite, ALUSrcA}); end
      n_checks++; if ({ALUSrcB, ResultSrc} !== 4'b1010) begin n_fail++; $display("FAIL fetch_src got=%b exp=1010", {ALUSrcB, ResultSrc}); end
      step();
      n_checks++; if ({state, ALUSrcA, RegW} !== {4'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_decode got=%b exp=000110", {state, ALUSrcA, RegW}); end
      step();
      n_checks++; if (state !== 4'd4) begin n_fail++; $display("FAIL add_execi_state got=%0d exp=4", state); end
      n_checks++; if ({ALUControl, shiftOp, ALUSrcB} !== {4'b0100, 3'd3, 2'b01}) begin n_fail++; $display("FAIL add_execi_ctrl got=%b exp=010001101", {ALUControl, shiftOp, ALUSrcB}); end
      n_checks++; if ({FlagW, RegW} !== 5'b00000) begin n_fail++; $display("FAIL add_execi_flags got=%b exp=00000", {FlagW, RegW}); end
      step();
      n_checks++; if ({state, RegW, PCWrite, ResultSrc} !== {4'd5, 1'b1, 1'b0, 2'b00}) begin n_fail++; $display("FAIL add_aluwb got=%b exp=01011000", {state, RegW, PCWrite, ResultSrc}); end
      step();
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL add_return got=%0d exp=0", state); end
      $display("test_add_imm done");
   endtask

   task automatic test_cmp_reg();
      Funct = 6'b010101; Instr = 8'h00; Rd = 4'd0;
      step();
      step();
      n_checks++; if (state !== 4'd3) begin n_fail++; $display("FAIL cmp_state got=%0d exp=3", state); end
      n_checks++; if ({FlagW, ALUControl, shiftOp, RegW} !== {4'b1111, 4'b1010, 3'd0, 1'b0}) begin n_fail++; $display("FAIL cmp_ctrl got=%b exp=111110100000", {FlagW, ALUControl, shiftOp, RegW}); end
      step();
      n_checks++; if ({state, RegW} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL cmp_return got=%b exp=00000", {state, RegW}); end
      $display("test_cmp_reg done");
   endtask

   task automatic test_rrx_mov_pc();
      Funct = 6'b011011; Instr = 8'h06; Rd = 4'd15;
      step();
      step();
      n_checks++; if ({state, shiftOp} !== {4'd3, 3'd4}) begin n_fail++; $display("FAIL rrx_shift got=%b exp=0011100", {state, shiftOp}); end
      n_checks++; if ({FlagW, ALUControl} !== {4'b1110, 4'b1101}) begin n_fail++; $display("FAIL movs_flags got=%b exp=11101101", {FlagW, ALUControl}); end
      step();
      n_checks++; if ({state, RegW, PCWrite} !== {4'd5, 2'b11}) begin n_fail++; $display("FAIL mov_pc_wb got=%b exp=010111", {state, RegW, PCWrite}); end
      step();
      $display("test_rrx_mov_pc done");
   endtask

   task automatic test_rshift();
      Funct = 6'b001000; Instr = 8'h05; Rd = 4'd2;
      step();
      step();
      n_checks++; if ({state, registerShift, shiftOp} !== {4'd2, 1'b1, 3'd5}) begin n_fail++; $display("FAIL rshift_state got=%b exp=00101101", {state, registerShift, shiftOp}); end
      step();
      n_checks++; if ({state, registerShift, shiftOp, FlagW} !== {4'd3, 1'b0, 3'd2, 4'd0}) begin n_fail++; $display("FAIL rshift_exec got=%b exp=001100100000", {state, registerShift, shiftOp, FlagW}); end
      step();
      step();
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rshift_return got=%0d exp=0", state); end
      $display("test_rshift done");
   endtask

   task automatic test_ldrsh();
      Op = 2'b00; Funct = 6'b000001; Instr = 8'h0F; Rd = 4'd3;
      step();
      step();
      n_checks++; if ({state, bus0.memSelect, ALUSrcB} !== {4'd6, 3'b101, 2'b01}) begin n_fail++; $display("FAIL ldrsh_memadr got=%b exp=011010101", {state, bus0.memSelect, ALUSrcB}); end
      set_ready(1'b0);
      step();
      n_checks++; if ({state, bus0.mem_req, bus0.AdrSrc, bus0.memSelect} !== {4'd7, 2'b11, 3'b101}) begin n_fail++; $display("FAIL ldrsh_memrd got=%b exp=011111101", {state, bus0.mem_req, bus0.AdrSrc, bus0.memSelect}); end
      step();
      step();
      n_checks++; if (state !== 4'd7) begin n_fail++; $display("FAIL ldrsh_wait got=%0d exp=7", state); end
      set_ready(1'b1);
      step();
      n_checks++; if ({state, RegW, ResultSrc, PCWrite, bus0.memSelect} !== {4'd8, 1'b1, 2'b01, 1'b0, 3'b101}) begin n_fail++; $display("FAIL ldrsh_memwb got=%b exp=10001010101", {state, RegW, ResultSrc, PCWrite, bus0.memSelect}); end
      step();
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL ldrsh_return got=%0d exp=0", state); end
      $display("test_ldrsh done");
   endtask

   task automatic test_store_load();
      Op = 2'b01; Funct = 6'b000100; Instr = 8'h00; Rd = 4'd4;
      step();
      step();
      n_checks++; if ({state, bus0.memSelect} !== {4'd6, 3'b000}) begin n_fail++; $display("FAIL strb_memadr got=%b exp=0110000", {state, bus0.memSelect}); end
      step();
      n_checks++; if ({state, bus0.MemW, bus0.mem_req, bus0.AdrSrc} !== {4'd9, 3'b111}) begin n_fail++; $display("FAIL strb_memwr got=%b exp=1001111", {state, bus0.MemW, bus0.mem_req, bus0.AdrSrc}); end
      step();
      Funct = 6'b000001;
      step();
      step();
      n_checks++; if (bus0.memSelect !== 3'b010) begin n_fail++; $display("FAIL ldr_word_sel got=%b exp=010", bus0.memSelect); end
      step();
      step();
      step();
      Op = 2'b00; Funct = 6'b000000; Instr = 8'h0F;
      step();
      step();
      n_checks++; if ({state, bus0.memSelect} !== {4'd6, 3'b001}) begin n_fail++; $display("FAIL store_unsigned_sel got=%b exp=0110001", {state, bus0.memSelect}); end
      step();
      step();
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL store_return got=%0d exp=0", state); end
      $display("test_store_load done");
   endtask

   task automatic test_branch();
      Op = 2'b10; Funct = 6'b010000;
      step();
      step();
      n_checks++; if ({state, PCWrite, RegW, linkSelect} !== {4'd10, 3'b111}) begin n_fail++; $display("FAIL bl_ctrl got=%b exp=1010111", {state, PCWrite, RegW, linkSelect}); end
      n_checks++; if ({ImmSrc, ALUSrcB} !== 4'b1001) begin n_fail++; $display("FAIL bl_src got=%b exp=1001", {ImmSrc, ALUSrcB}); end
      step();
      Funct = 6'b000000;
      step();
      step();
      n_checks++; if ({state, PCWrite, RegW, linkSelect} !== {4'd10, 3'b100}) begin n_fail++; $display("FAIL b_ctrl got=%b exp=1010100", {state, PCWrite, RegW, linkSelect}); end
      step();
      $display("test_branch done");
   endtask

   task automatic test_reset_mid_access();
      Op = 2'b01; Funct = 6'b000100;
      step();
      step();
      set_ready(1'b0);
      step();
      n_checks++; if ({state, bus0.MemW} !== {4'd9, 1'b1}) begin n_fail++; $display("FAIL midreset_pre got=%b exp=10011", {state, bus0.MemW}); end
      #3 reset = 1'b0;
      #1;
      n_checks++; if ({state, bus0.MemW, bus0.mem_req} !== {4'd0, 2'b00}) begin n_fail++; $display("FAIL midreset_async got=%b exp=000000", {state, bus0.MemW, bus0.mem_req}); end
      #1 reset = 1'b1;
      step();
      n_checks++; if ({state, bus0.mem_req, bus0.MemW} !== {4'd0, 2'b10}) begin n_fail++; $display("FAIL midreset_restart got=%b exp=000010", {state, bus0.mem_req, bus0.MemW}); end
      $display("test_reset_mid_access done");
   endtask

   task automatic test_wait_boundary();
      Op = 2'b00; Funct = 6'b010101; Instr = 8'h00;
      set_ready(1'b0);
      for (int i = 1; i <= 14; i++) begin
         step();
         n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL wait14_hold cycle=%0d got=%0d exp=0", i, state); end
      end
      set_ready(1'b1);
      step();
      n_checks++; if ({state, fault} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL wait14_ready got=%b exp=00010", {state, fault}); end
      step();
      step();
      $display("test_wait_boundary done");
   endtask

   task automatic test_timeout();
      set_ready(1'b0);
      for (int i = 1; i <= 14; i++) begin
         step();
      end
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL timeout_before got=%0d exp=0", state); end
      step();
      n_checks++; if ({state, fault, bus0.mem_req} !== {4'd11, 2'b10}) begin n_fail++; $display("FAIL timeout_fault got=%b exp=101110", {state, fault, bus0.mem_req}); end
      set_ready(1'b1);
      step();
      step();
      n_checks++; if ({state, fault, IRWrite, PCWrite} !== {4'd11, 3'b100}) begin n_fail++; $display("FAIL fault_sticky got=%b exp=1011100", {state, fault, IRWrite, PCWrite}); end
      #3 reset = 1'b0;
      #1;
      n_checks++; if ({state, fault} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL fault_async_clear got=%b exp=00000", {state, fault}); end
      #1 reset = 1'b1;
      step();
      $display("test_timeout done");
   endtask

   task automatic test_op11();
      Op = 2'b11; Funct = 6'b000000;
      step();
      step();
      n_checks++; if ({state, fault} !== {4'd11, 1'b1}) begin n_fail++; $display("FAIL op11_fault got=%b exp=10111", {state, fault}); end
      pulse_reset();
      $display("test_op11 done");
   endtask

   task automatic test_halfword_disabled();
      pulse_reset();
      Op = 2'b00; Funct = 6'b000001; Instr = 8'h0B; Rd = 4'd5; set_ready(1'b1);
      step();
      n_checks++; if ({state, state_h} !== {4'd1, 4'd1}) begin n_fail++; $display("FAIL ldrh_decode got=%b exp=00010001", {state, state_h}); end
      step();
      n_checks++; if ({state, bus0.memSelect} !== {4'd6, 3'b001}) begin n_fail++; $display("FAIL ldrh_enabled got=%b exp=0110001", {state, bus0.memSelect}); end
      n_checks++; if ({state_h, fault_h} !== {4'd11, 1'b1}) begin n_fail++; $display("FAIL ldrh_disabled got=%b exp=10111", {state_h, fault_h}); end
      step();
      n_checks++; if ({state_h, bus1.mem_req} !== {4'd11, 1'b0}) begin n_fail++; $display("FAIL ldrh_disabled_sticky got=%b exp=10110", {state_h, bus1.mem_req}); end
      $display("test_halfword_disabled done");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      set_ready(1'b0);
      reset = 1'b0;
      step();
      step();
      test_reset();
      test_add_imm();
      test_cmp_reg();
      test_rrx_mov_pc();
      test_rshift();
      test_ldrsh();
      test_store_load();
      test_branch();
      test_reset_mid_access();
      set_ready(1'b1);
      test_wait_boundary();
      test_timeout();
      test_op11();
      test_halfword_disabled();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
